// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and a core stall request.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiplies finish once the multiplier runs out of set bits).
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    input  logic            read_req,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dbz_op_q, dbz_op_d;
    logic [XLEN-1:0] raw_rs_q, raw_rs_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;
    logic            div_by_zero_q, div_by_zero_d;

    logic            rs_neg, rt_neg, last_iter;
    logic [XLEN-1:0] rs_mag, rt_mag, quo_fix, rem_fix;
    logic [XLEN:0]   rem_trial, div_sub;
    logic [PW-1:0]   prod_fix;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_div_d      = is_div_q;
        neg_d         = neg_q;
        neg_rem_d     = neg_rem_q;
        dbz_op_d      = dbz_op_q;
        raw_rs_d      = raw_rs_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        acc_d         = acc_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;

        // op[0]==0 selects the signed variants; magnitudes are taken at accept.
        rs_neg = ~op[0] & rs_val[XLEN-1];
        rt_neg = ~op[0] & rt_val[XLEN-1];
        rs_mag = rs_neg ? -rs_val : rs_val;
        rt_mag = rt_neg ? -rt_val : rt_val;

        // Restoring divide: partial remainder lives in acc_q's upper half, dividend/quotient in the lower.
        rem_trial = acc_q[PW-1:XLEN-1];
        div_sub   = rem_trial - {1'b0, mcand_q[XLEN-1:0]};

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[PW-1:XLEN] : acc_q[PW-1:XLEN];

`ifdef MULDIV_EARLY_OUT_EN
        last_iter = (cnt_q == CW'(XLEN - 1)) || (!is_div_q && ((mplier_q >> 1) == '0));
`else
        last_iter = (cnt_q == CW'(XLEN - 1));
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RUN;
                    cnt_d         = '0;
                    is_div_d      = op[1];
                    neg_d         = rs_neg ^ rt_neg;
                    neg_rem_d     = rs_neg;
                    dbz_op_d      = op[1] & (rt_val == '0);
                    raw_rs_d      = rs_val;
                    mcand_d       = {{XLEN{1'b0}}, op[1] ? rt_mag : rs_mag};
                    mplier_d      = rt_mag;
                    acc_d         = op[1] ? {{XLEN{1'b0}}, rs_mag} : '0;
                    div_by_zero_d = 1'b0;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    if (!div_sub[XLEN]) acc_d = {div_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else                acc_d = {acc_q[PW-2:0], 1'b0};
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[PW-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end else if (dbz_op_q) begin
                    hi_d          = raw_rs_q;
                    lo_d          = '1;
                    div_by_zero_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            is_div_q      <= 1'b0;
            neg_q         <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_op_q      <= 1'b0;
            raw_rs_q      <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_div_q      <= is_div_d;
            neg_q         <= neg_d;
            neg_rem_q     <= neg_rem_d;
            dbz_op_q      <= dbz_op_d;
            raw_rs_q      <= raw_rs_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            acc_q         <= acc_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign stall       = busy & (read_req | start | mthi | mtlo);
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random traffic against an arithmetic model.
// Honours MULDIV_EARLY_OUT_EN the same way the design does.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        read_req = 1'b0;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .read_req(read_req), .busy(busy), .stall(stall),
        .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from MIPS arithmetic.
    function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
        int sa, sb;
        longint la, lb, p, q, r;
        longint unsigned pu;
        sa = a; sb = b; la = sa; lb = sb;
        case (o)
            2'b00: begin p = la * lb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin pu = {32'b0, a} * {32'b0, b}; h = pu[63:32]; l = pu[31:0]; end
            2'b10: begin
                if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                else begin q = la / lb; r = la % lb; h = r[31:0]; l = q[31:0]; end
            end
            default: begin
                if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                else begin h = a % b; l = a / b; end
            end
        endcase
    endfunction

    function automatic int run_len(input logic [1:0] o, input logic [31:0] b);
        int n;
        logic [31:0] mag;
        n = 32;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            mag = (!o[0] && b[31]) ? -b : b;
            while (n > 1 && !mag[n-1]) n--;
        end
`else
        mag = b;
        if (o[1] && mag == 0) n = 32;
`endif
        return n;
    endfunction

    int          m_busy_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1'b1;
                end
            end else if (start) begin
                model_op(op, rs_val, rt_val, p_hi, p_lo);
                p_dbz = op[1] && (rt_val == 0);
                m_dbz = 1'b0;
                m_busy_left = run_len(op, rt_val) + 1;
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (check_en) begin
                check_output("busy", busy, m_busy_left > 0);
                check_output("done", done, m_done);
                check_output("stall", stall, (m_busy_left > 0) && (read_req || start || mthi || mtlo));
                check_output("hi", hi, m_hi);
                check_output("lo", lo, m_lo);
                check_output("div_by_zero", div_by_zero, m_dbz);
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        bit got;
        nbusy = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
        check_output("done_seen", got, 1'b1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    int nb;

    initial begin
        reset = 1'b1;
        @(posedge clk);
        check_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("rst_hi", hi, 32'h0);
        check_output("rst_lo", lo, 32'h0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_stall", stall, 1'b0);
        check_output("rst_done", done, 1'b0);
        reset = 1'b0;

        mthi = 1'b1; wdata = 32'h00001234;
        @(negedge clk);
        mthi = 1'b0;
        check_output("mthi_hi", hi, 32'h00001234);
        check_output("mthi_lo", lo, 32'h0);

        apply_stimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(nb);
        check_output("multu_busy_cycles", nb, 33);
        check_output("multu_hi", hi, 32'hFFFFFFFE);
        check_output("multu_lo", lo, 32'h00000001);
        @(negedge clk);
        check_output("multu_done_pulse", done, 1'b0);

        apply_stimulus(2'b00, 32'hFFFFFFFD, 32'h7);
        wait_done(nb);
        check_output("mult_hi", hi, 32'hFFFFFFFF);
        check_output("mult_lo", lo, 32'hFFFFFFEB);

        apply_stimulus(2'b10, 32'hFFFFFFF9, 32'h2);
        wait_done(nb);
        check_output("div_busy_cycles", nb, 33);
        check_output("div_lo", lo, 32'hFFFFFFFD);
        check_output("div_hi", hi, 32'hFFFFFFFF);

        apply_stimulus(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(nb);
        check_output("div_ovf_lo", lo, 32'h80000000);
        check_output("div_ovf_hi", hi, 32'h0);

        apply_stimulus(2'b11, 32'h7, 32'h0);
        wait_done(nb);
        check_output("dbz_busy_cycles", nb, 33);
        check_output("dbz_lo", lo, 32'hFFFFFFFF);
        check_output("dbz_hi", hi, 32'h7);
        check_output("dbz_flag", div_by_zero, 1'b1);
        @(negedge clk);
        check_output("dbz_flag_held", div_by_zero, 1'b1);
        apply_stimulus(2'b01, 32'h2, 32'h3);
        check_output("dbz_cleared", div_by_zero, 1'b0);
        wait_done(nb);

        // Dependent read and illegal start/mtlo while an op is in flight.
        apply_stimulus(2'b11, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        read_req = 1'b1;
        #1;
        check_output("stall_read", stall, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'h5; rt_val = 32'h5; mtlo = 1'b1; wdata = 32'hDEADBEEF;
        #1;
        check_output("stall_start_mtlo", stall, 1'b1);
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        wait_done(nb);
        check_output("stall_done_cycle", stall, 1'b0);
        check_output("read_lo", lo, 32'd14);
        check_output("read_hi", hi, 32'd2);
        read_req = 1'b0;
        @(negedge clk);
        check_output("no_restart", busy, 1'b0);

        // Reset in the middle of a multiply.
        mthi = 1'b1; wdata = 32'hAAAA0000;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h00005555;
        @(negedge clk);
        mtlo = 1'b0;
        apply_stimulus(2'b01, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
`ifndef MULDIV_EARLY_OUT_EN
        check_output("run_hi_held", hi, 32'hAAAA0000);
        check_output("run_lo_held", lo, 32'h00005555);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("midrst_busy", busy, 1'b0);
        check_output("midrst_hi", hi, 32'h0);
        check_output("midrst_lo", lo, 32'h0);
        check_output("midrst_done", done, 1'b0);

`ifdef MULDIV_EARLY_OUT_EN
        apply_stimulus(2'b01, 32'd3, 32'd5);
        wait_done(nb);
        check_output("early_busy_cycles", nb, 4);
        check_output("early_lo", lo, 32'd15);
`endif

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 399) == 0);
            start    = ($urandom_range(0, 3) == 0);
            op       = 2'($urandom_range(0, 3));
            rs_val   = pick();
            rt_val   = pick();
            mthi     = ($urandom_range(0, 7) == 0);
            mtlo     = ($urandom_range(0, 7) == 0);
            wdata    = $urandom;
            read_req = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; read_req = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
